// File: rtl/multi_shooting_cooldown_if.sv
// multi_shooting_cooldown_if: shooter-side bus of the multi-channel cooldown arbiter (ammo signals with SHOOTING_AMMO_EN)
interface multi_shooting_cooldown_if #(
  parameter int NUM_CHANNELS   = 4,
  parameter int COOLDOWN_WIDTH = 6,
  parameter int BURST_WIDTH    = 3
);
  localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  logic                      startOfFrame;
  logic [NUM_CHANNELS-1:0]   fire_command;
  logic [COOLDOWN_WIDTH-1:0] shooting_cooldown;
  logic [BURST_WIDTH-1:0]    burst_len;
  logic [COOLDOWN_WIDTH-1:0] burst_gap;
  logic [NUM_CHANNELS-1:0]   shooting_pulse;
  logic [CH_W-1:0]           shot_channel;
  logic [NUM_CHANNELS-1:0]   busy;
`ifdef SHOOTING_AMMO_EN
  logic [NUM_CHANNELS-1:0]   ammo_refill;
  logic [NUM_CHANNELS-1:0]   out_of_ammo;
  modport master (output startOfFrame, fire_command, shooting_cooldown, burst_len, burst_gap, ammo_refill,
                  input  shooting_pulse, shot_channel, busy, out_of_ammo);
  modport slave  (input  startOfFrame, fire_command, shooting_cooldown, burst_len, burst_gap, ammo_refill,
                  output shooting_pulse, shot_channel, busy, out_of_ammo);
`else
  modport master (output startOfFrame, fire_command, shooting_cooldown, burst_len, burst_gap,
                  input  shooting_pulse, shot_channel, busy);
  modport slave  (input  startOfFrame, fire_command, shooting_cooldown, burst_len, burst_gap,
                  output shooting_pulse, shot_channel, busy);
`endif
endinterface

// File: rtl/multi_shooting_cooldown.sv
// multi_shooting_cooldown: per-channel burst/cooldown FSMs with round-robin single-launch arbiter (optional ammo via SHOOTING_AMMO_EN)
module multi_shooting_cooldown #(
  parameter int NUM_CHANNELS   = 4,
  parameter int COOLDOWN_WIDTH = 6,
  parameter int BURST_WIDTH    = 3
`ifdef SHOOTING_AMMO_EN
  , parameter int AMMO_WIDTH   = 5
`endif
) (
  input logic clk,
  input logic resetN,
  multi_shooting_cooldown_if.slave bus
);
  localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [1:0] {READY, GAP, COOLDOWN} state_t;
  state_t                    state      [NUM_CHANNELS];
  state_t                    state_nx   [NUM_CHANNELS];
  logic [COOLDOWN_WIDTH-1:0] count      [NUM_CHANNELS];
  logic [COOLDOWN_WIDTH-1:0] count_nx   [NUM_CHANNELS];
  logic [BURST_WIDTH-1:0]    shots_left [NUM_CHANNELS];
  logic [BURST_WIDTH-1:0]    shots_nx   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   eligible, gnt, has_ammo;
  logic [CH_W-1:0]           ptr, gnt_idx;
  logic                      gnt_any;
  int                        idx;
  logic                      multi_shot;
  assign multi_shot = bus.burst_len > BURST_WIDTH'(1);
`ifdef SHOOTING_AMMO_EN
  logic [AMMO_WIDTH-1:0] ammo [NUM_CHANNELS];
  // ammo bookkeeping: refill beats a same-cycle grant decrement
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++)
      ammo[i] <= (!resetN || bus.ammo_refill[i]) ? '1 : gnt[i] ? ammo[i] - 1'b1 : ammo[i];
  end
  // an empty channel can neither start nor continue a burst
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) has_ammo[i] = ammo[i] != '0;
  end
  assign bus.out_of_ammo = ~has_ammo;
`else
  assign has_ammo = '1;
`endif
  // a channel may launch when idle, or mid-burst once its gap has expired
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++)
      eligible[i] = bus.fire_command[i] && has_ammo[i] &&
                    (state[i] == READY || (state[i] == GAP && count[i] == '0));
  end
  // round-robin: first eligible channel at or after the pointer wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(ptr) + k) % NUM_CHANNELS;
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    gnt = gnt_any ? NUM_CHANNELS'(1) << gnt_idx : '0;
  end
  // per-channel next state: grant loads beat frame decrement, eligible-but-losing channels hold
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_nx[i] = state[i];
      count_nx[i] = count[i];
      shots_nx[i] = shots_left[i];
      if (gnt[i] && state[i] == READY) begin
        shots_nx[i] = multi_shot ? bus.burst_len - 1'b1 : '0;
        count_nx[i] = multi_shot ? bus.burst_gap : bus.shooting_cooldown;
        state_nx[i] = multi_shot ? GAP : COOLDOWN;
      end else if (gnt[i]) begin
        shots_nx[i] = shots_left[i] - 1'b1;
        count_nx[i] = shots_left[i] == BURST_WIDTH'(1) ? bus.shooting_cooldown : bus.burst_gap;
        state_nx[i] = shots_left[i] == BURST_WIDTH'(1) ? COOLDOWN : GAP;
      end else if (state[i] == GAP && count[i] == '0 && !eligible[i]) begin
        shots_nx[i] = '0;
        count_nx[i] = bus.shooting_cooldown;
        state_nx[i] = COOLDOWN;
      end else if (state[i] == COOLDOWN && count[i] == '0) begin
        state_nx[i] = READY;
      end else if (state[i] != READY && bus.startOfFrame && count[i] != '0) begin
        count_nx[i] = count[i] - 1'b1;
      end
    end
  end
  // state registers and registered outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]      <= READY;
        count[i]      <= '0;
        shots_left[i] <= '0;
      end
      ptr                <= '0;
      bus.shooting_pulse <= '0;
      bus.shot_channel   <= '0;
      bus.busy           <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]      <= state_nx[i];
        count[i]      <= count_nx[i];
        shots_left[i] <= shots_nx[i];
        bus.busy[i]   <= state_nx[i] != READY;
      end
      ptr                <= !gnt_any ? ptr : gnt_idx == CH_W'(NUM_CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
      bus.shooting_pulse <= gnt;
      bus.shot_channel   <= gnt_any ? gnt_idx : bus.shot_channel;
    end
  end
endmodule

// File: doc/multi_shooting_cooldown.md
Name: multi_shooting_cooldown

Overview:
Multi-channel, burst-capable successor to the single-shooter cooldown. Each channel is one shooter (player or an enemy slot) and has its own frame-based cooldown and a burst FSM. A round-robin arbiter lets at most one channel fire per clock, because the missile spawner accepts one launch per cycle. Sits between the shooter controllers and the missile spawner.

Parameters:
NUM_CHANNELS, 4, number of independent shooters
COOLDOWN_WIDTH, 6, width of cooldown and burst-gap counters, in frames
BURST_WIDTH, 3, width of burst-length input and shots-left counter
AMMO_WIDTH, 5, width of ammo counter (used only with SHOOTING_AMMO_EN)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
fire_command  in  NUM_CHANNELS  per-channel fire request (level)
shooting_cooldown  in  COOLDOWN_WIDTH  frames of cooldown after a burst ends (shared)
burst_len  in  BURST_WIDTH  shots per burst (shared)
burst_gap  in  COOLDOWN_WIDTH  frames between shots inside a burst (shared)
shooting_pulse  out  NUM_CHANNELS  one-hot, one-cycle fire pulse
shot_channel  out  clog2(NUM_CHANNELS)  index of the pulsing channel; valid while any pulse is set
busy  out  NUM_CHANNELS  channel state is not READY
ammo_refill  in  NUM_CHANNELS  present only with SHOOTING_AMMO_EN
out_of_ammo  out  NUM_CHANNELS  present only with SHOOTING_AMMO_EN

Behaviour:
- Reset, synchronous on resetN=0 at the clk edge:
  - all channels READY; count=0, shots_left=0
  - shooting_pulse=0, shot_channel=0, busy=0
  - round-robin pointer=0
- Per-channel states: READY, GAP, COOLDOWN.
- eligible[i] = fire_command[i] && (READY, or GAP with count==0).
- Arbiter: among eligible channels, grant the first at or after the pointer, wrapping modulo NUM_CHANNELS. Pointer becomes grant+1, wrapping. With no grant, the pointer holds.
- Pulse latency: shooting_pulse[g] and shot_channel=g are registered. They assert in the clock after the request is sampled, for exactly one cycle.
- Granted channel from READY:
  - burst_len is sampled; an effective length of 0 is treated as 1.
  - Effective length 1: count<=shooting_cooldown, go to COOLDOWN.
  - Otherwise: shots_left<=len-1, count<=burst_gap, go to GAP.
- Granted channel in GAP:
  - shots_left is decremented.
  - If the result is 0: count<=shooting_cooldown, go to COOLDOWN.
  - Else: count<=burst_gap, stay in GAP.
- GAP with count==0 and fire_command[i]=0: burst aborted. count<=shooting_cooldown, shots_left<=0, go to COOLDOWN.
- Eligible but not granted: state and count held. The channel retries every cycle. No shot is lost while the request is held.
- GAP/COOLDOWN with startOfFrame=1 and count!=0: count decrements by 1 and never wraps below 0.
- COOLDOWN with count==0: go to READY on the next clock. A channel can fire no earlier than the following cycle.
- A cooldown or gap value of 0 is legal:
  - COOLDOWN with 0: READY one clock later.
  - GAP with 0: the next burst shot is eligible in the next cycle.
- Grant and startOfFrame in the same cycle on the same channel: the load wins and the decrement is skipped.
- shooting_cooldown, burst_len and burst_gap are sampled only at grant time. Changing them mid-burst does not affect counts already loaded.
- busy[i] is registered and equals (state!=READY).

Optional Feature:
SHOOTING_AMMO_EN
- Defined:
  - Each channel has an ammo counter, reset to all-ones.
  - Each grant decrements it.
  - When ammo==0 the channel is never eligible and out_of_ammo[i]=1; a GAP burst stops and the channel goes to COOLDOWN.
  - ammo_refill[i] reloads all-ones next clock. Refill has priority over a same-cycle decrement.
- Not defined: unlimited shots; ammo_refill and out_of_ammo ports and all ammo logic are absent.

Test Plan:
1. Single shot. NUM_CHANNELS=4, burst_len=1, cooldown=3. Hold fire[0] -> pulse[0] one cycle after request; next pulse[0] 3 startOfFrames plus 1 clk later; busy[0] high in between.
2. Burst. burst_len=3, gap=2, cooldown=5, fire[1] held -> 3 pulses spaced 2 frames apart; then no pulse for 5 frames; then the next burst starts.
3. Burst abort. burst_len=4; drop fire[2] after the 2nd pulse -> no 3rd pulse; COOLDOWN loaded with cooldown; READY after cooldown frames plus 1 clk.
4. Arbitration. All 4 fire on the same cycle from READY, pointer=0 -> pulses on channels 0,1,2,3 on consecutive cycles; shot_channel=0,1,2,3; no pulse dropped.
5. Edge values. cooldown=0, burst_len=0, fire[3] held -> pulse every 2 clocks. Then assert resetN=0 mid-COOLDOWN -> next clock: busy=0, pulse=0, pointer=0.
6. With SHOOTING_AMMO_EN and AMMO_WIDTH=2 -> exactly 3 pulses, then out_of_ammo[0]=1. ammo_refill[0] -> firing resumes after cooldown.
